// File: rtl/pwm_feedback_ctrl.sv
// pwm_feedback_ctrl
// PWM generator for the converter control path. A phase accumulator produces
// ticks that advance a CNT_W-bit ramp; pwm compares the ramp with duty. In
// closed loop a filtered comparator input steps duty through a hysteresis
// error counter; in open loop duty follows duty_set. Duty only changes at
// the period boundary, so every PWM period is glitch free.
//
// Run-state FSM:
//   state  | meaning
//   S_IDLE | enable low; datapath held cleared, en=0
//   S_ARM  | enable high, waiting for the first accumulator tick
//   S_RUN  | running; en=1 and pwm may assert
module pwm_feedback_ctrl #(
  parameter int CNT_W     = 6,
  parameter int ACC_W     = 17,
  parameter int DUTY_INIT = 30,
  parameter int DUTY_MIN  = 0,
  parameter int DUTY_MAX  = 63,
  parameter int FILT_LEN  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic [CNT_W-1:0] duty_set,
  input  logic [15:0]      clock_step,
  input  logic [15:0]      fb_interval,
  input  logic             fb,
  output logic             pwm,
  output logic             en,
  output logic [CNT_W-1:0] duty,
  output logic             period_tick,
  output logic             sat
);

  localparam logic [CNT_W-1:0] RAMP_MAX = '1;
  localparam logic [CNT_W-1:0] D_INIT   = CNT_W'(DUTY_INIT);
  localparam logic [CNT_W-1:0] D_MIN    = CNT_W'(DUTY_MIN);
  localparam logic [CNT_W-1:0] D_MAX    = CNT_W'(DUTY_MAX);
  localparam int               FC_W     = (FILT_LEN > 2) ? $clog2(FILT_LEN) : 1;
  localparam logic [FC_W-1:0]  FILT_LAST = FC_W'(FILT_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2
  } run_state_t;

  run_state_t state, state_n;
  logic       run_n;

  logic [ACC_W-1:0]   acc;
  logic [ACC_W:0]     acc_sum;
  logic               tick;
  logic [CNT_W-1:0]   ramp;

  logic               fb_s1, fb_s2, fb_f;
  logic [FC_W-1:0]    filt_cnt;

  logic signed [17:0] err, err_n, thr, neg_thr;
  logic               duty_update;
  logic [CNT_W-1:0]   duty_set_cl;
  logic               duty_set_clamped;

  assign acc_sum = {1'b0, acc} + {{(ACC_W + 1 - 16){1'b0}}, clock_step};
  assign en      = (state == S_RUN);

  // Run-state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Run-state transitions; run_n is the next-cycle "running" qualifier for pwm
  always_comb begin
    state_n = state;
    run_n   = 1'b0;
    case (state)
      S_IDLE:  if (enable) state_n = S_ARM;
      S_ARM: begin
        if (!enable)   state_n = S_IDLE;
        else if (tick) state_n = S_RUN;
      end
      S_RUN:   if (!enable) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    run_n = (state_n == S_RUN);
  end

  // Phase accumulator; the registered carry is the ramp tick
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (!enable) begin
      acc  <= '0;
      tick <= 1'b0;
    end else begin
      acc  <= acc_sum[ACC_W-1:0];
      tick <= acc_sum[ACC_W];
    end
  end

  // Ramp counter and wrap strobe (strobe coincides with ramp becoming 0)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ramp        <= '0;
      period_tick <= 1'b0;
    end else if (!enable) begin
      ramp        <= '0;
      period_tick <= 1'b0;
    end else begin
      period_tick <= tick && (ramp == RAMP_MAX);
      if (tick) ramp <= ramp + CNT_W'(1);
    end
  end

  // Registered PWM compare, gated until the first tick after enable
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pwm <= 1'b0;
    else       pwm <= run_n && (ramp < duty);
  end

  // Two-flop synchroniser for the asynchronous comparator input
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fb_s1 <= 1'b0;
      fb_s2 <= 1'b0;
    end else begin
      fb_s1 <= fb;
      fb_s2 <= fb_s1;
    end
  end

  // Debounce: fb_f follows fb_s2 only after FILT_LEN consecutive differing samples
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fb_f     <= 1'b0;
      filt_cnt <= '0;
    end else if (fb_s2 == fb_f) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_LAST) begin
      fb_f     <= fb_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FC_W'(1);
    end
  end

  // Error step, thresholds and open-loop clamp
  always_comb begin
    err_n            = fb_f ? (err - 18'sd1) : (err + 18'sd1);
    thr              = $signed({2'b00, fb_interval});
    neg_thr          = -thr;
    duty_update      = period_tick && enable;
    duty_set_cl      = duty_set;
    duty_set_clamped = 1'b0;
    if (int'(duty_set) < DUTY_MIN) begin
      duty_set_cl      = D_MIN;
      duty_set_clamped = 1'b1;
    end else if (int'(duty_set) > DUTY_MAX) begin
      duty_set_cl      = D_MAX;
      duty_set_clamped = 1'b1;
    end
  end

  // Duty, error counter and saturation flag; only move at an enabled period wrap
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      duty <= D_INIT;
      err  <= '0;
      sat  <= 1'b0;
    end else if (!enable) begin
      err  <= '0;
    end else if (duty_update) begin
      if (mode) begin
        duty <= duty_set_cl;
        err  <= '0;
        sat  <= duty_set_clamped;
      end else if (err_n <= neg_thr) begin
        err <= '0;
        if (int'(duty) <= DUTY_MIN) begin
          sat <= 1'b1;
        end else begin
          duty <= duty - CNT_W'(1);
          sat  <= 1'b0;
        end
      end else if (err_n >= thr) begin
        err <= '0;
        if (int'(duty) >= DUTY_MAX) begin
          sat <= 1'b1;
        end else begin
          duty <= duty + CNT_W'(1);
          sat  <= 1'b0;
        end
      end else begin
        err <= err_n;
        sat <= 1'b0;
      end
    end
  end

endmodule
